// File: rtl/decoder_scan_ctrl.sv
// Scan controller for a 3-to-8 decoder: walks the enabled channels of a latched mask,
// holding each one for a dwell time with a one-cycle break-before-make gap between channels.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_l_q, dwell_l_d;
  logic [7:0]         mask_l_q, mask_l_d;
  logic               mode_l_q, mode_l_d;
  logic [3:0]         next_hit;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above cur
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Counter counts down the remaining ACTIVE cycles, so a dwell of 0 behaves like 1
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    en_d      = en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    dwell_l_d = dwell_l_q;
    mask_l_d  = mask_l_q;
    mode_l_d  = mode_l_q;
    next_hit  = next_above(mask_l_q, sel_q);

    case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !stop) begin
          mask_l_d  = mask;
          dwell_l_d = dwell;
          mode_l_d  = mode;
          if (mask != 8'h00) begin
            state_d = ACTIVE;
            sel_d   = lowest_set(mask);
            en_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = dwell_load(dwell);
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ACTIVE: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = BLANK;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      BLANK: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (next_hit[3] || mode_l_q) begin
          state_d = ACTIVE;
          sel_d   = next_hit[3] ? next_hit[2:0] : lowest_set(mask_l_q);
          en_d    = 1'b1;
          cnt_d   = dwell_load(dwell_l_q);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      dwell_l_q <= '0;
      mask_l_q  <= '0;
      mode_l_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      dwell_l_q <= dwell_l_d;
      mask_l_q  <= mask_l_d;
      mode_l_q  <= mode_l_d;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: a reference model turns each scan request into
// expected en bursts (channel, first cycle, length) and done pulses; a monitor compares.
module tb_decoder_scan_ctrl;
  localparam int DWELL_W = 8;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               stop  = 1'b0;
  logic               mode  = 1'b0;
  logic [7:0]         mask  = 8'h00;
  logic [DWELL_W-1:0] dwell = '0;
  logic [2:0]         sel;
  logic               en, busy, done;

  decoder_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .mask(mask), .dwell(dwell), .sel(sel), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  typedef struct {
    bit is_done;
    int ch;
    int t0;
    int len;
    bit flag;
  } ev_t;

  ev_t exp_q[$];
  int  checks  = 0;
  int  errors  = 0;
  int  rst_seq = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, pcyc);
    end
  endtask

  // Reference model: start sampled at the edge after cycle s, abort (stop or reset) issued in
  // cycle abort (-1 = none). Bursts are D+1 cycles apart; the done pulse follows the last blank.
  task automatic model_scan(input int s, input logic [7:0] m, input int dw, input bit md,
                            input int abort);
    int d;
    int b;
    int chs[$];
    ev_t e;
    d = (dw == 0) ? 1 : dw;
    b = s + 1;
    for (int i = 0; i < 8; i++) if (m[i]) chs.push_back(i);
    if (chs.size() == 0) begin
      e.is_done = 1'b1; e.ch = 0; e.t0 = s + 1; e.len = 0; e.flag = 1'b0;
      exp_q.push_back(e);
      return;
    end
    forever begin
      foreach (chs[j]) begin
        if (abort >= 0 && b > abort) return;
        e.is_done = 1'b0;
        e.ch      = chs[j];
        e.t0      = b;
        e.flag    = (abort >= 0 && abort <= b + d - 1);
        e.len     = e.flag ? (abort - b + 1) : d;
        exp_q.push_back(e);
        b += d + 1;
      end
      if (!md) begin
        if (abort < 0 || abort >= b) begin
          e.is_done = 1'b1; e.ch = 0; e.t0 = b; e.len = 1; e.flag = 1'b0;
          exp_q.push_back(e);
        end
        return;
      end
    end
  endtask

  // Issues one scan at the current negedge; optionally scrambles inputs and re-pulses start
  // while busy, and aborts with stop or an asynchronous reset pulse at cycle s+abort_off.
  task automatic run_scan(input logic [7:0] m, input int dw, input bit md, input int abort_off,
                          input bit use_rst, input bit noise);
    int s, d, k, done_c, abort, last_c, fin;
    s      = pcyc;
    d      = (dw == 0) ? 1 : dw;
    k      = $countones(m);
    done_c = s + 1 + k * (d + 1);
    abort  = (abort_off >= 0) ? s + abort_off : -1;
    if (k == 0)  last_c = s;
    else if (md) last_c = abort - 1;
    else         last_c = (abort >= 0 && abort < done_c) ? abort - 1 : done_c - 1;
    fin = md ? abort : ((abort > done_c) ? abort : done_c);
    fin = fin + 3;
    mask  = m;
    dwell = DWELL_W'(dw);
    mode  = md;
    start = 1'b1;
    model_scan(s, m, dw, md, abort);
    @(negedge clk);
    start = 1'b0;
    for (int c = s + 1; c <= fin; c++) begin
      if (abort >= 0 && c == abort) begin
        if (use_rst) begin
          #1 rst_n = 1'b0;
          #1;
          chk("async_rst_sel", sel, 0);
          chk("async_rst_en", en, 0);
          chk("async_rst_busy", busy, 0);
          chk("async_rst_done", done, 0);
          rst_seq++;
          rst_n = 1'b1;
        end else begin
          stop = 1'b1;
        end
      end else if (noise) begin
        mask  = 8'($urandom);
        dwell = DWELL_W'($urandom);
        mode  = 1'($urandom);
        if (c <= last_c && (c == s + 2 || $urandom_range(0, 7) == 0)) start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
    end
  endtask

  // Monitor
  initial begin : monitor
    logic       prev_en   = 1'b0;
    logic       prev_busy = 1'b0;
    logic [2:0] prev_sel  = 3'd0;
    int         run_t0    = 0;
    int         run_len   = 0;
    int         seen_rst  = 0;
    bit         rst_hit;
    ev_t        e;
    forever begin
      @(negedge clk);
      rst_hit = (seen_rst != rst_seq);
      seen_rst = rst_seq;
      if (en === 1'b1) begin
        chk("en_implies_busy", busy, 1);
        if (prev_en) begin
          chk("sel_stable_in_burst", sel, prev_sel);
          run_len++;
        end else begin
          run_t0  = pcyc;
          run_len = 1;
        end
      end else begin
        if (!rst_hit) chk("sel_holds_while_off", sel, prev_sel);
        if (prev_en) begin
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            checks++; errors++;
            $display("FAIL unexpected_burst actual=sel%0d@%0d required=none", prev_sel, run_t0);
          end else begin
            e = exp_q.pop_front();
            chk("burst_sel", prev_sel, e.ch);
            chk("burst_start", run_t0, e.t0);
            chk("burst_len", run_len, e.len);
            chk("busy_after_burst", busy, e.flag ? 0 : 1);
          end
        end
      end
      if (done !== 1'b0) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", pcyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", pcyc, e.t0);
          chk("busy_low_with_done", busy, 0);
          chk("en_low_with_done", en, 0);
          if (e.len != 0) chk("busy_fell_with_done", prev_busy, 1);
        end
      end
      prev_en   = en;
      prev_busy = busy;
      prev_sel  = sel;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] m;
    int         dw, ab;
    bit         md, ur;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_sel", sel, 0);
    chk("reset_en", en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_scan(8'hFF, 2, 1'b0, -1, 1'b0, 1'b1);
    run_scan(8'hA4, 1, 1'b1, 20, 1'b0, 1'b1);
    run_scan(8'h26, 3, 1'b1, 10, 1'b0, 1'b1);
    run_scan(8'h01, 0, 1'b0, -1, 1'b0, 1'b0);
    run_scan(8'h00, 3, 1'b0, -1, 1'b0, 1'b0);
    run_scan(8'h10, 2, 1'b1, 14, 1'b0, 1'b1);

    mask  = 8'hFF;
    dwell = DWELL_W'(2);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (5) @(negedge clk);

    run_scan(8'h0A, 4, 1'b1, 7, 1'b1, 1'b0);
    run_scan(8'h0A, 2, 1'b0, -1, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      m  = 8'($urandom);
      dw = $urandom_range(0, 4);
      md = 1'($urandom);
      ab = (md || $urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : -1;
      ur = (ab >= 0) && ($urandom_range(0, 4) == 0);
      run_scan(m, dw, md, ab, ur, 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("leftover_events", exp_q.size(), 0);
    chk("final_en", en, 0);
    chk("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 8, width of the dwell count input and the internal dwell counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 stop  input  1  abort the current scan; return to IDLE.
REQ-006 mode  input  1  0 = single pass, 1 = continuous wrap.
REQ-007 mask  input  8  channel enable mask; bit n set = channel n is scanned.
REQ-008 dwell  input  DWELL_W  cycles each channel is held enabled; 0 treated as 1.
REQ-009 sel  output  3  channel index; drives the 3-to-8 decoder select.
REQ-010 en  output  1  decoder enable; high only while a channel is being driven.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on normal completion of a single pass.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-014 The FSM SHALL have states IDLE, ACTIVE and BLANK.
REQ-015 IDLE: en=0, busy=0, sel holds its last value; start=1 with stop=0 SHALL latch mask, dwell and mode into internal registers.
REQ-016 In IDLE, start=1 with a nonzero latched mask SHALL go to ACTIVE, with sel = lowest set mask bit, en=1 and busy=1 visible in the cycle after start.
REQ-017 In IDLE, start=1 with mask=0 SHALL stay IDLE, pulse done for one cycle, and never assert en.
REQ-018 ACTIVE: en=1 for exactly max(dwell,1) consecutive cycles, then go to BLANK.
REQ-019 BLANK: en=0 for exactly 1 cycle (break-before-make); sel SHALL change only on the BLANK-to-ACTIVE transition.
REQ-020 After BLANK, sel SHALL advance to the next set mask bit above the current index, then go to ACTIVE.
REQ-021 When no set bit exists above the current index in mode=1, the next channel SHALL be the lowest set bit (wrap 7 to 0 region).
REQ-022 When no set bit exists above the current index in mode=0, the block SHALL go to IDLE with done=1 for one cycle, coincident with busy falling.
REQ-023 mask, dwell and mode changes while busy=1 SHALL be ignored; the latched copies govern the whole scan.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 stop=1 in ACTIVE or BLANK SHALL go to IDLE on the next edge, with en=0 and busy=0 and no done pulse.
REQ-026 start=1 and stop=1 in the same cycle in IDLE: stop wins; no scan starts and no done pulse occurs.
REQ-027 With a single set mask bit in mode=1, the block SHALL repeat that channel: ACTIVE dwell cycles, BLANK 1 cycle, and so on.
REQ-028 A single pass over k set bits with dwell d (d>=1) SHALL take exactly k*(d+1) cycles from the first en=1 cycle to the done cycle inclusive of the final BLANK.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, sel=0, en=0, busy=0, done=0, and clear the dwell counter and latched registers.
REQ-030 Reset deasserted mid-operation SHALL leave the block in IDLE; no scan resumes without a new start.

Verification
REQ-031 Reset mid-scan (sel=3, en=1), pulse rst_n low between edges -> sel=0, en=0, busy=0 before the next edge; a later start begins at the lowest set bit.
REQ-032 mode=0, mask=8'hFF, dwell=2, start -> sel 0..7, each with en high 2 cycles and low 1 cycle; done pulses once 24 cycles after the first en; busy falls with done.
REQ-033 mode=1, mask=8'b1010_0100, dwell=1 -> sel sequence 2,5,7,2,5,7... with en pattern 1,0 repeating; done never asserts.
REQ-034 mode=1 scan at sel=5, then stop=1 for 1 cycle -> next edge en=0, busy=0, done=0; mask changed during the scan has no effect before the stop.
REQ-035 dwell=0, mask=8'h01, mode=0 -> en high exactly 1 cycle then done; separately, mask=0 with start -> done pulse next cycle and en stays 0.
REQ-036 start pulsed while busy, and start+stop in the same cycle in IDLE -> no restart and no scan respectively; sel and en sequences unchanged.
